// File: rtl/menu_pkg.sv
// menu_pkg: shared state encoding, key bit positions and cursor wrap helper for the level-select menu
package menu_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_BROWSE, ST_CONFIRM, ST_DONE} state_t;
  localparam int KEY_UP = 0;
  localparam int KEY_DOWN = 1;
  localparam int KEY_ENTER = 2;
  localparam int KEY_ESC = 3;
  // One cursor step with wrap-around at both ends of an n-entry menu
  function automatic logic [2:0] wrap_step(logic [2:0] cur, logic up, int n);
    return up ? ((int'(cur) == n - 1) ? 3'd0 : cur + 3'd1) : ((cur == 3'd0) ? 3'(n - 1) : cur - 3'd1);
  endfunction
endpackage

// File: rtl/menu_ctrl_if.sv
// menu_ctrl_if: keyboard levels in, renderer/game-FSM signals out
interface menu_ctrl_if;
  logic en;
  logic [9:0] key_down;
  logic [2:0] cursor;
  logic [2:0] level;
  logic start;
  logic back;
  logic confirming;
  logic [1:0] state;
  modport master (output en, key_down, input cursor, level, start, back, confirming, state);
  modport slave (input en, key_down, output cursor, level, start, back, confirming, state);
endinterface

// File: rtl/key_repeat.sv
// key_repeat: rising-edge step plus auto-repeat timer for one held key
module key_repeat #(
  parameter int REPEAT_DELAY = 25000000,
  parameter int REPEAT_PERIOD = 10000000
) (
  input  logic clk,
  input  logic rst,
  input  logic key,
  input  logic clr,
  output logic step
);
  localparam int W = $clog2(REPEAT_DELAY + 1);
  localparam logic [W-1:0] DLY = W'(REPEAT_DELAY);
  localparam logic [W-1:0] RLD = W'(REPEAT_DELAY - REPEAT_PERIOD + 1);
  logic prev, rise, rep;
  logic [W-1:0] cnt;
  assign rise = key & ~prev;
  assign rep = key & prev & (cnt == DLY);
  assign step = rise | rep;
  // cnt is 0 while disarmed; an edge arms it, and each repeat reloads it so the next one lands a period later
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      prev <= 1'b0;
      cnt <= '0;
    end else begin
      prev <= key;
      cnt <= (clr || !key) ? '0 : rise ? W'(1) : rep ? RLD : (cnt != '0) ? cnt + 1'b1 : '0;
    end
endmodule

// File: rtl/menu_ctrl.sv
// menu_ctrl: level-select menu FSM with cursor, confirm flash and start/back pulses
module menu_ctrl #(
  parameter int N_ITEMS = 5,
  parameter int REPEAT_DELAY = 25000000,
  parameter int REPEAT_PERIOD = 10000000,
  parameter int CONFIRM_CYCLES = 50000000
) (
  input logic clk,
  input logic rst,
  menu_ctrl_if.slave m
);
  import menu_pkg::*;
  localparam int CW = $clog2(CONFIRM_CYCLES);
  localparam logic [2:0] TOP = 3'(N_ITEMS - 1);
  state_t st;
  logic [CW-1:0] tmr;
  logic ent_p, esc_p, ent_e, esc_e, up_s, dn_s, clr, unused_keys;
  assign ent_e = m.key_down[KEY_ENTER] & ~ent_p;
  assign esc_e = m.key_down[KEY_ESC] & ~esc_p;
  assign clr = (m.key_down[KEY_UP] & m.key_down[KEY_DOWN]) | (st != ST_BROWSE);
  assign unused_keys = ^m.key_down[9:4];
  assign m.state = st;
  key_repeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)) u_up (
    .clk(clk), .rst(rst), .key(m.key_down[KEY_UP]), .clr(clr), .step(up_s));
  key_repeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)) u_dn (
    .clk(clk), .rst(rst), .key(m.key_down[KEY_DOWN]), .clr(clr), .step(dn_s));
  // Menu FSM: browse with cursor moves, timed confirm, commit to level and pulse start
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      st <= ST_IDLE;
      tmr <= '0;
      ent_p <= 1'b0;
      esc_p <= 1'b0;
      m.cursor <= TOP;
      m.level <= '0;
      m.start <= 1'b0;
      m.back <= 1'b0;
      m.confirming <= 1'b0;
    end else begin
      ent_p <= m.key_down[KEY_ENTER];
      esc_p <= m.key_down[KEY_ESC];
      m.start <= 1'b0;
      m.back <= 1'b0;
      if (!m.en) begin
        st <= ST_IDLE;
        tmr <= '0;
        m.confirming <= 1'b0;
      end else
        case (st)
          ST_IDLE: begin
            st <= ST_BROWSE;
            m.cursor <= TOP - m.level;
          end
          ST_BROWSE:
            if (ent_e) begin
              st <= ST_CONFIRM;
              tmr <= '0;
              m.confirming <= 1'b1;
            end else if (esc_e) begin
              st <= ST_IDLE;
              m.back <= 1'b1;
            end else if ((up_s && !m.key_down[KEY_DOWN]) || (dn_s && !m.key_down[KEY_UP]))
              m.cursor <= wrap_step(m.cursor, up_s, N_ITEMS);
          ST_CONFIRM:
            if (esc_e) begin
              st <= ST_BROWSE;
              m.confirming <= 1'b0;
            end else if (tmr == CW'(CONFIRM_CYCLES - 1)) begin
              st <= ST_DONE;
              m.level <= TOP - m.cursor;
              m.start <= 1'b1;
              m.confirming <= 1'b0;
            end else
              tmr <= tmr + 1'b1;
          default: ;
        endcase
    end
endmodule
